// File: rtl/ucdp_clk_or_ctrl_pkg.sv
// Shared types for the two-source clock OR break-before-make sequencer.
package ucdp_clk_or_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_NONE = 2'b00;
    localparam sel_t SEL_A    = 2'b01;
    localparam sel_t SEL_B    = 2'b10;
    localparam sel_t SEL_ILL  = 2'b11;

endpackage

// File: rtl/ucdp_clk_or_ctrl.sv
// Break-before-make enable sequencer for two clock gates feeding an OR combiner.
// Every switch inserts an all-off gap of max(gap_i, MIN_GAP) control-clock cycles.
module ucdp_clk_or_ctrl
    import ucdp_clk_or_ctrl_pkg::*;
#(
    parameter int GAP_W   = 4,
    parameter int MIN_GAP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [1:0]       sel_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             rdy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [1:0]       sel_o,
    output logic             ena_a_o,
    output logic             ena_b_o
);

    localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

    state_e           state_reg, state_next;
    logic [GAP_W-1:0] cnt_reg, cnt_next;
    sel_t             tgt_reg, tgt_next;
    sel_t             sel_reg, sel_next;
    logic             ena_a_reg, ena_a_next;
    logic             ena_b_reg, ena_b_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [GAP_W-1:0] eff_gap;

    assign eff_gap = (gap_i < MIN_GAP_V) ? MIN_GAP_V : gap_i;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tgt_next   = tgt_reg;
        sel_next   = sel_reg;
        ena_a_next = ena_a_reg;
        ena_b_next = ena_b_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_i) begin
                    if (sel_i == SEL_ILL) begin
                        err_next = 1'b1;
                    end else if (sel_i == sel_reg) begin
                        done_next = 1'b1;
                    end else begin
                        // Break first: both gates off for the whole gap.
                        ena_a_next = 1'b0;
                        ena_b_next = 1'b0;
                        sel_next   = SEL_NONE;
                        tgt_next   = sel_i;
                        cnt_next   = eff_gap - GAP_W'(1);
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - GAP_W'(1);
                end else begin
                    sel_next   = tgt_reg;
                    ena_a_next = (tgt_reg == SEL_A);
                    ena_b_next = (tgt_reg == SEL_B);
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            tgt_reg   <= SEL_NONE;
            sel_reg   <= SEL_NONE;
            ena_a_reg <= 1'b0;
            ena_b_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tgt_reg   <= tgt_next;
            sel_reg   <= sel_next;
            ena_a_reg <= ena_a_next;
            ena_b_reg <= ena_b_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Single-flop decodes only, so the status outputs stay glitch-free.
    assign rdy_o   = (state_reg == ST_IDLE);
    assign busy_o  = (state_reg == ST_GAP);
    assign done_o  = done_reg;
    assign err_o   = err_reg;
    assign sel_o   = sel_reg;
    assign ena_a_o = ena_a_reg;
    assign ena_b_o = ena_b_reg;

endmodule

// File: doc/ucdp_clk_or_ctrl.md
# ucdp_clk_or_ctrl

Break-before-make sequencer for a two-source clock OR. Runs on an always-on control clock and drives the enables of two external clock gates, one per source, whose outputs feed the OR combiner. At most one source enable is high at any time. Every switch inserts a programmable all-off gap, so the OR output never carries overlapping pulses from both sources.

## Interface
Parameters:
- `GAP_W`, default 4: width of the gap-length input and of the internal counter.
- `MIN_GAP`, default 1: hard lower bound on all-off cycles per switch. Legal range is 1..2^GAP_W-1.

Ports:
- `clk_i`  in  1  always-on control clock; the only clock in the block.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  switch request; valid/ready handshake with `rdy_o`.
- `sel_i`  in  2  target source: 2'b00 none, 2'b01 A, 2'b10 B, 2'b11 illegal. Sampled only on acceptance.
- `gap_i`  in  GAP_W  requested all-off cycles. Sampled only on acceptance.
- `rdy_o`  out  1  ready to accept a request.
- `done_o`  out  1  one-cycle pulse when a legal request completes.
- `err_o`  out  1  one-cycle pulse when an illegal request is accepted.
- `busy_o`  out  1  gap sequence in progress.
- `sel_o`  out  2  currently enabled source, same encoding as `sel_i`.
- `ena_a_o`  out  1  gate enable for source A.
- `ena_b_o`  out  1  gate enable for source B.

## Operation
- Reset values: `rdy_o`=1, `done_o`=0, `err_o`=0, `busy_o`=0, `sel_o`=2'b00, `ena_a_o`=0, `ena_b_o`=0. After reset the block holds both sources off and waits for a request. It never enables a source on its own.
- State machine states: IDLE and GAP.
- A request is accepted on a rising edge where `req_i` and `rdy_o` are both 1. `rdy_o` is 1 exactly when the state is IDLE.
- IDLE, accepted, `sel_i`=2'b11: stay in IDLE, pulse `err_o`, leave enables and `sel_o` unchanged.
- IDLE, accepted, `sel_i` equal to `sel_o`: stay in IDLE, pulse `done_o`, leave enables unchanged. No gap is inserted.
- IDLE, accepted, any other legal `sel_i`:
  - clear both enables;
  - set `sel_o` to 2'b00;
  - latch the target;
  - load the counter with D-1, where D = max(`gap_i`, `MIN_GAP`);
  - go to GAP.
- GAP, counter not zero: decrement the counter.
- GAP, counter zero: set `sel_o` to the latched target and raise its enable (target none raises no enable), pulse `done_o`, go to IDLE.
- `req_i` is ignored while in GAP. An in-flight switch cannot be aborted. The requester holds `req_i`, `sel_i` and `gap_i` stable until the request is accepted.
- `busy_o` is 1 exactly when the state is GAP.
- Invariant: `ena_a_o` and `ena_b_o` are never both 1.
- Invariant: `sel_o` always matches the enables (01 means A on, 10 means B on, 00 means both off).
- Reset asserted mid-GAP: return to the reset values immediately and asynchronously. The pending switch is lost and `done_o` is not pulsed.
- All outputs come straight from flops, so they drive the clock gates without glitches.

## Timing
- Request accepted at edge N with effective gap D:
  - both enables are 0 from edge N;
  - the new enable rises at edge N+D;
  - `done_o` is high for the one cycle after edge N+D;
  - `busy_o` is high from edge N to edge N+D;
  - `rdy_o` is low over the same interval.
- The next request can be accepted at edge N+D+1 at the earliest. It may overlap the `done_o` cycle.
- A no-change request or an illegal request gives its `done_o` or `err_o` pulse in the cycle after acceptance, with zero gap.
- Counter width is GAP_W. D never exceeds 2^GAP_W-1, so the counter cannot wrap.
- The all-off interval is D control-clock cycles. The integrator picks `gap_i` to cover gate latency plus one period of the slower source clock.

## Structure
- Shared package `ucdp_clk_or_ctrl_pkg` holds:
  - the state enum for IDLE and GAP;
  - the 2-bit select typedef;
  - constants SEL_NONE, SEL_A, SEL_B, SEL_ILL.
- The block is single-module, with the FSM, counter and output registers in one file.
- Clock gates and the OR combiner are instantiated by the parent, not inside this block.

## Test plan
- Reset: with `rst_i` pulsed mid-simulation, all outputs equal their reset values within the same cycle, and stay there until a request arrives.
- Switch none→A with `gap_i`=0 and `MIN_GAP`=1: `ena_a_o` rises 1 edge after acceptance, `done_o` pulses once, `busy_o` is high for 1 cycle.
- Switch A→B with `gap_i`=5: both enables are low for exactly 5 cycles, `ena_b_o` rises at acceptance+5, `sel_o`=2'b10, and the two enables never overlap.
- Request A while A is already selected: `done_o` pulses 1 cycle later and `ena_a_o` never drops. Request `sel_i`=2'b11: `err_o` pulses and all state is unchanged.
- Request B with `gap_i`=15, then assert `rst_i` at gap cycle 7: both enables are 0, `sel_o`=0, and no `done_o` appears.
- Back-to-back requests with `req_i` held high: the second request is accepted at edge N+D+1 and not before. `req_i` asserted during GAP is not accepted.
